// File: rtl/pi_request_queue.sv
// pi_request_queue: gathers the Pi's staged register writes into complete
// 68k bus requests and queues them in an in-order FIFO. The head request is
// offered to the bus engine through a valid/ack handshake. Completion is
// signalled with a done pulse, which also carries read data back to the Pi.
// Optional build macro PIQ_DROP_COUNT_EN adds a saturating counter of
// dropped commits on DROP_COUNT. Without it, DROP_COUNT is tied to zero.
// Pi register map: 0 DATA_LO, 1 DATA_HI, 2 ADDR_LO, 3 ADDR_HI (commits).
module pi_request_queue #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic        SYSCLK,
  input  logic        nRESET,
  input  logic        PI_WR_STROBE,
  input  logic [2:0]  PI_A,
  input  logic [15:0] PI_DATA_IN,
  output logic        REQ_VALID,
  output logic [23:0] REQ_ADDR,
  output logic [31:0] REQ_DATA,
  output logic [1:0]  REQ_SIZE,
  output logic        REQ_READ,
  output logic [2:0]  REQ_FC,
  input  logic        REQ_ACK,
  input  logic        REQ_DONE,
  input  logic [31:0] REQ_RDATA,
  output logic [31:0] RD_DATA,
  output logic        BUSY,
  output logic        FULL,
  output logic        OVERFLOW,
  output logic [7:0]  DROP_COUNT
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [2:0] REG_DATA_LO = 3'd0;
  localparam logic [2:0] REG_DATA_HI = 3'd1;
  localparam logic [2:0] REG_ADDR_LO = 3'd2;
  localparam logic [2:0] REG_ADDR_HI = 3'd3;

  // Pointer-width constants; pointers carry one extra wrap bit.
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] PTR_ZERO  = {(DEPTH_LOG2 + 1){1'b0}};
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef struct packed {
    logic [2:0]  fc;
    logic        read;
    logic [1:0]  size;
    logic [23:0] addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  logic [15:0]         stage_data_lo_q, stage_data_lo_d;
  logic [15:0]         stage_data_hi_q, stage_data_hi_d;
  logic [15:0]         stage_addr_q, stage_addr_d;
  entry_t              mem_q [DEPTH];
  entry_t              head_q, head_d;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  state_t              state_q, state_d;
  logic                is_read_q, is_read_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                overflow_q, overflow_d;
  logic                req_valid_q, req_valid_d;
  logic                busy_q, busy_d;
  logic                full_q, full_d;

  logic                commit_s;
  logic                pop_s;
  logic                push_s;
  logic                drop_s;
  logic                full_now_s;
  logic [DEPTH_LOG2:0] count_s;
  logic [DEPTH_LOG2:0] count_d;
  entry_t              new_entry_s;

  // Staging register updates from Pi writes; ADDR_HI is not staged, it commits.
  always_comb begin
    stage_data_lo_d = stage_data_lo_q;
    stage_data_hi_d = stage_data_hi_q;
    stage_addr_d    = stage_addr_q;
    if (PI_WR_STROBE) begin
      case (PI_A)
        REG_DATA_LO: stage_data_lo_d = PI_DATA_IN;
        REG_DATA_HI: stage_data_hi_d = PI_DATA_IN;
        REG_ADDR_LO: stage_addr_d    = PI_DATA_IN;
        default:     stage_addr_d    = stage_addr_q;
      endcase
    end else begin
      stage_addr_d = stage_addr_q;
    end
  end

  // Commit decode, FIFO push/pop/drop decisions and next pointers.
  always_comb begin
    commit_s         = PI_WR_STROBE && (PI_A == REG_ADDR_HI);
    new_entry_s.fc   = PI_DATA_IN[13:11];
    new_entry_s.read = PI_DATA_IN[10];
    new_entry_s.size = PI_DATA_IN[9:8];
    new_entry_s.addr = {PI_DATA_IN[7:0], stage_addr_q};
    new_entry_s.data = {stage_data_hi_q, stage_data_lo_q};
    count_s          = wr_ptr_q - rd_ptr_q;
    full_now_s       = (count_s == DEPTH_CNT);
    pop_s            = (state_q == ST_ISSUE) && REQ_ACK;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_s           = commit_s && (!full_now_s || pop_s);
    drop_s           = commit_s && full_now_s && !pop_s;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  // Next head entry; bypass the incoming entry when it lands in the head slot.
  always_comb begin
    if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = new_entry_s;
    end else begin
      head_d = mem_q[rd_ptr_d[DEPTH_LOG2-1:0]];
    end
  end

  // Request FSM next state, read-data capture and registered status outputs.
  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q | drop_s;
    case (state_q)
      ST_IDLE: begin
        if (count_d != PTR_ZERO) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (REQ_ACK) begin
          is_read_d = head_q.read;
          state_d   = ST_WAIT_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (REQ_DONE) begin
          if (is_read_q) begin
            rd_data_d = REQ_RDATA;
          end else begin
            rd_data_d = rd_data_q;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_valid_d = (state_d == ST_ISSUE);
    busy_d      = (count_d != PTR_ZERO) || (state_d != ST_IDLE);
    full_d      = (count_d == DEPTH_CNT);
  end

  // FIFO storage: entries written at the write pointer on an accepted commit.
  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= new_entry_s;
    end
  end

  // Control, staging and output registers.
  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      stage_data_lo_q <= 16'h0000;
      stage_data_hi_q <= 16'h0000;
      stage_addr_q    <= 16'h0000;
      head_q          <= '0;
      wr_ptr_q        <= PTR_ZERO;
      rd_ptr_q        <= PTR_ZERO;
      state_q         <= ST_IDLE;
      is_read_q       <= 1'b0;
      rd_data_q       <= 32'h0000_0000;
      overflow_q      <= 1'b0;
      req_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      full_q          <= 1'b0;
    end else begin
      stage_data_lo_q <= stage_data_lo_d;
      stage_data_hi_q <= stage_data_hi_d;
      stage_addr_q    <= stage_addr_d;
      head_q          <= head_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      state_q         <= state_d;
      is_read_q       <= is_read_d;
      rd_data_q       <= rd_data_d;
      overflow_q      <= overflow_d;
      req_valid_q     <= req_valid_d;
      busy_q          <= busy_d;
      full_q          <= full_d;
    end
  end

`ifdef PIQ_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped commits.
  always_comb begin
    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_COUNT = drop_cnt_q;
`else
  assign DROP_COUNT = 8'h00;
`endif

  assign REQ_VALID = req_valid_q;
  assign REQ_ADDR  = head_q.addr;
  assign REQ_DATA  = head_q.data;
  assign REQ_SIZE  = head_q.size;
  assign REQ_READ  = head_q.read;
  assign REQ_FC    = head_q.fc;
  assign RD_DATA   = rd_data_q;
  assign BUSY      = busy_q;
  assign FULL      = full_q;
  assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_pi_request_queue.sv
// Directed testbench for pi_request_queue (default DEPTH_LOG2 = 2).
// Register map assumed: 0 DATA_LO, 1 DATA_HI, 2 ADDR_LO, 3 ADDR_HI.
module tb_pi_request_queue;

  logic        SYSCLK;
  logic        nRESET;
  logic        PI_WR_STROBE;
  logic [2:0]  PI_A;
  logic [15:0] PI_DATA_IN;
  logic        REQ_VALID;
  logic [23:0] REQ_ADDR;
  logic [31:0] REQ_DATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_READ;
  logic [2:0]  REQ_FC;
  logic        REQ_ACK;
  logic        REQ_DONE;
  logic [31:0] REQ_RDATA;
  logic [31:0] RD_DATA;
  logic        BUSY;
  logic        FULL;
  logic        OVERFLOW;
  logic [7:0]  DROP_COUNT;

  int checks_q;
  int errors_q;

`ifdef PIQ_DROP_COUNT_EN
  localparam logic [7:0] EXP_DROP_ONE = 8'd1;
  localparam logic [7:0] EXP_DROP_SAT = 8'd255;
`else
  localparam logic [7:0] EXP_DROP_ONE = 8'd0;
  localparam logic [7:0] EXP_DROP_SAT = 8'd0;
`endif

  pi_request_queue #(.DEPTH_LOG2(2)) dut (
    .SYSCLK       (SYSCLK),
    .nRESET       (nRESET),
    .PI_WR_STROBE (PI_WR_STROBE),
    .PI_A         (PI_A),
    .PI_DATA_IN   (PI_DATA_IN),
    .REQ_VALID    (REQ_VALID),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_DATA     (REQ_DATA),
    .REQ_SIZE     (REQ_SIZE),
    .REQ_READ     (REQ_READ),
    .REQ_FC       (REQ_FC),
    .REQ_ACK      (REQ_ACK),
    .REQ_DONE     (REQ_DONE),
    .REQ_RDATA    (REQ_RDATA),
    .RD_DATA      (RD_DATA),
    .BUSY         (BUSY),
    .FULL         (FULL),
    .OVERFLOW     (OVERFLOW),
    .DROP_COUNT   (DROP_COUNT)
  );

  // 100 MHz system clock.
  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic pi_wr(input logic [2:0] a, input logic [15:0] d);
    PI_WR_STROBE = 1'b1;
    PI_A         = a;
    PI_DATA_IN   = d;
    tick();
    PI_WR_STROBE = 1'b0;
  endtask

  // Wait (bounded) for the head to be offered, check it, ack it, then finish it.
  task automatic serve(input string tag, input logic [23:0] exp_addr);
    int n;
    n = 0;
    while (!REQ_VALID && (n < 8)) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 64'(REQ_VALID), 64'(1'b1));
    check_eq({tag, "_addr"}, 64'(REQ_ADDR), 64'(exp_addr));
    REQ_ACK = 1'b1;
    tick();
    REQ_ACK  = 1'b0;
    REQ_DONE = 1'b1;
    tick();
    REQ_DONE = 1'b0;
  endtask

  initial begin
    checks_q     = 0;
    errors_q     = 0;
    nRESET       = 1'b0;
    PI_WR_STROBE = 1'b0;
    PI_A         = 3'd0;
    PI_DATA_IN   = 16'h0000;
    REQ_ACK      = 1'b0;
    REQ_DONE     = 1'b0;
    REQ_RDATA    = 32'h0000_0000;
    #12;
    nRESET = 1'b1;
    tick();

    // Reset state.
    check_eq("rst_valid", 64'(REQ_VALID), 64'(1'b0));
    check_eq("rst_busy", 64'(BUSY), 64'(1'b0));
    check_eq("rst_full", 64'(FULL), 64'(1'b0));
    check_eq("rst_ovf", 64'(OVERFLOW), 64'(1'b0));
    check_eq("rst_rdata", 64'(RD_DATA), 64'(32'h0));
    check_eq("rst_drop", 64'(DROP_COUNT), 64'(8'h0));
    check_eq("rst_addr", 64'(REQ_ADDR), 64'(24'h0));

    // Single write request.
    pi_wr(3'd0, 16'h1234);
    pi_wr(3'd1, 16'hABCD);
    pi_wr(3'd2, 16'h0100);
    check_eq("stage_no_valid", 64'(REQ_VALID), 64'(1'b0));
    pi_wr(3'd3, 16'h0000);
    check_eq("w_valid", 64'(REQ_VALID), 64'(1'b1));
    check_eq("w_addr", 64'(REQ_ADDR), 64'(24'h000100));
    check_eq("w_data", 64'(REQ_DATA), 64'(32'hABCD1234));
    check_eq("w_read", 64'(REQ_READ), 64'(1'b0));
    check_eq("w_busy", 64'(BUSY), 64'(1'b1));
    REQ_ACK = 1'b1;
    tick();
    REQ_ACK = 1'b0;
    check_eq("w_ack_valid", 64'(REQ_VALID), 64'(1'b0));
    check_eq("w_ack_busy", 64'(BUSY), 64'(1'b1));
    tick();
    check_eq("w_wait_busy", 64'(BUSY), 64'(1'b1));
    REQ_DONE  = 1'b1;
    REQ_RDATA = 32'h5555_5555;
    tick();
    REQ_DONE = 1'b0;
    check_eq("w_done_busy", 64'(BUSY), 64'(1'b0));
    check_eq("w_no_rdata", 64'(RD_DATA), 64'(32'h0));

    // Unmapped register address does not commit.
    pi_wr(3'd5, 16'hFFFF);
    tick();
    check_eq("ign_busy", 64'(BUSY), 64'(1'b0));

    // Read request reusing staged DATA/ADDR_LO.
    pi_wr(3'd3, 16'h04BF);
    check_eq("r_valid", 64'(REQ_VALID), 64'(1'b1));
    check_eq("r_addr", 64'(REQ_ADDR), 64'(24'hBF0100));
    check_eq("r_read", 64'(REQ_READ), 64'(1'b1));
    REQ_ACK = 1'b1;
    tick();
    REQ_ACK = 1'b0;
    check_eq("r_busy", 64'(BUSY), 64'(1'b1));
    REQ_DONE  = 1'b1;
    REQ_RDATA = 32'h0000_C0DE;
    tick();
    REQ_DONE = 1'b0;
    check_eq("r_rdata", 64'(RD_DATA), 64'(32'h0000C0DE));
    check_eq("r_busy_low", 64'(BUSY), 64'(1'b0));
    REQ_DONE  = 1'b1;
    REQ_RDATA = 32'hDEAD_BEEF;
    tick();
    REQ_DONE = 1'b0;
    check_eq("done_idle_ign", 64'(RD_DATA), 64'(32'h0000C0DE));

    // Fill four entries without acking; size 2, fc 5 on each.
    for (int i = 0; i < 4; i++) begin
      pi_wr(3'd2, 16'h1000 + 16'(i));
      pi_wr(3'd3, 16'h6A10 + 16'(i));
      if (i == 2) check_eq("fill3_full", 64'(FULL), 64'(1'b0));
    end
    check_eq("fill_full", 64'(FULL), 64'(1'b1));
    check_eq("fill_ovf", 64'(OVERFLOW), 64'(1'b0));
    check_eq("fill_head", 64'(REQ_ADDR), 64'(24'h101000));
    check_eq("fill_size", 64'(REQ_SIZE), 64'(2'd2));
    check_eq("fill_fc", 64'(REQ_FC), 64'(3'd5));

    // Commit with simultaneous ack while full is accepted.
    pi_wr(3'd2, 16'h2000);
    REQ_ACK = 1'b1;
    pi_wr(3'd3, 16'h0020);
    REQ_ACK = 1'b0;
    check_eq("sim_full", 64'(FULL), 64'(1'b1));
    check_eq("sim_ovf", 64'(OVERFLOW), 64'(1'b0));
    check_eq("sim_head", 64'(REQ_ADDR), 64'(24'h111001));

    // Commit while full without pop is dropped.
    pi_wr(3'd2, 16'h3000);
    pi_wr(3'd3, 16'h0030);
    check_eq("drop_ovf", 64'(OVERFLOW), 64'(1'b1));
    check_eq("drop_full", 64'(FULL), 64'(1'b1));
    check_eq("drop_cnt1", 64'(DROP_COUNT), 64'(EXP_DROP_ONE));
    REQ_DONE = 1'b1;
    tick();
    REQ_DONE = 1'b0;

    // Drain in commit order; the dropped entry never appears.
    serve("q1", 24'h111001);
    serve("q2", 24'h121002);
    serve("q3", 24'h131003);
    serve("q4", 24'h202000);
    tick();
    check_eq("drain_busy", 64'(BUSY), 64'(1'b0));
    check_eq("drain_full", 64'(FULL), 64'(1'b0));
    check_eq("ovf_sticky", 64'(OVERFLOW), 64'(1'b1));

    // Asynchronous reset with three entries queued and ISSUE active.
    for (int i = 0; i < 3; i++) begin
      pi_wr(3'd3, 16'h0001);
    end
    check_eq("pre_rst_valid", 64'(REQ_VALID), 64'(1'b1));
    #2;
    nRESET = 1'b0;
    #1;
    check_eq("arst_valid", 64'(REQ_VALID), 64'(1'b0));
    check_eq("arst_busy", 64'(BUSY), 64'(1'b0));
    check_eq("arst_full", 64'(FULL), 64'(1'b0));
    check_eq("arst_ovf", 64'(OVERFLOW), 64'(1'b0));
    #2;
    nRESET = 1'b1;
    tick();
    tick();
    check_eq("post_rst_valid", 64'(REQ_VALID), 64'(1'b0));
    check_eq("post_rst_busy", 64'(BUSY), 64'(1'b0));
    pi_wr(3'd3, 16'h0055);
    check_eq("post_rst_addr", 64'(REQ_ADDR), 64'(24'h550000));
    check_eq("post_rst_data", 64'(REQ_DATA), 64'(32'h0));

    // Drop counter saturation.
    for (int i = 0; i < 3; i++) begin
      pi_wr(3'd3, 16'h0066);
    end
    check_eq("sat_full", 64'(FULL), 64'(1'b1));
    for (int i = 0; i < 300; i++) begin
      pi_wr(3'd3, 16'h0077);
    end
    check_eq("sat_drop", 64'(DROP_COUNT), 64'(EXP_DROP_SAT));
    check_eq("sat_ovf", 64'(OVERFLOW), 64'(1'b1));
    check_eq("sat_head", 64'(REQ_ADDR), 64'(24'h550000));

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
